// File: rtl/ber_prbs_sync_checker_pkg.sv
// -----------------------------------------------------------------------------
// ber_pkg
// Shared definitions for the BER tester PRBS generator and checker: polynomial
// select encoding, polynomial order/tap constants, the checker FSM state enum
// and a lookup mapping a select code to (order, t1, t2). Both ends of the link
// import this package so their polynomials cannot drift apart.
// -----------------------------------------------------------------------------
package ber_pkg;

   localparam int SEL_W  = 2;
   localparam int LFSR_W = 23;   // wide enough for the longest polynomial

   typedef enum logic [SEL_W-1:0] {
      SEL_PRBS7  = 2'b00,   // x^7  + x^6  + 1
      SEL_PRBS15 = 2'b01,   // x^15 + x^14 + 1
      SEL_PRBS20 = 2'b10,   // x^20 + x^3  + 1
      SEL_PRBS23 = 2'b11    // x^23 + x^18 + 1
   } poly_sel_e;

   localparam logic [4:0] PRBS7_ORD  = 5'd7,  PRBS7_T2  = 5'd6;
   localparam logic [4:0] PRBS15_ORD = 5'd15, PRBS15_T2 = 5'd14;
   localparam logic [4:0] PRBS20_ORD = 5'd20, PRBS20_T2 = 5'd3;
   localparam logic [4:0] PRBS23_ORD = 5'd23, PRBS23_T2 = 5'd18;

   // t1 always equals the polynomial order, but it is kept as its own field so
   // the prediction reads directly as s[t1-1] ^ s[t2-1].
   typedef struct packed {
      logic [4:0] order;
      logic [4:0] t1;
      logic [4:0] t2;
   } poly_cfg_t;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   function automatic poly_cfg_t poly_cfg(input poly_sel_e sel);
      poly_cfg_t cfg;
      cfg = '{order: PRBS7_ORD, t1: PRBS7_ORD, t2: PRBS7_T2};
      case (sel)
         SEL_PRBS7:  cfg = '{order: PRBS7_ORD,  t1: PRBS7_ORD,  t2: PRBS7_T2};
         SEL_PRBS15: cfg = '{order: PRBS15_ORD, t1: PRBS15_ORD, t2: PRBS15_T2};
         SEL_PRBS20: cfg = '{order: PRBS20_ORD, t1: PRBS20_ORD, t2: PRBS20_T2};
         SEL_PRBS23: cfg = '{order: PRBS23_ORD, t1: PRBS23_ORD, t2: PRBS23_T2};
         default:    cfg = '{order: PRBS7_ORD,  t1: PRBS7_ORD,  t2: PRBS7_T2};
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/ber_prbs_sync_checker_if.sv
// -----------------------------------------------------------------------------
// ber_prbs_sync_checker_if
// Bit-stream input and result bus of the PRBS checker.
//   enable      bit-valid; prbs_in is sampled only when high
//   select_chk  polynomial select (see ber_pkg::poly_sel_e)
//   prbs_in     received serial bit
//   clear       synchronous clear of counters and sat
//   locked      checker synchronised
//   err_pulse   one-cycle pulse per errored bit while locked
//   teb_out     total error bits (saturating)
//   ttb_out     total bits checked while locked (saturating)
//   sat         sticky saturation flag
// master = stream source / result reader, slave = checker.
// -----------------------------------------------------------------------------
interface ber_prbs_sync_checker_if #(
   parameter int TEB_W = 10,
   parameter int TTB_W = 32
) ();
   import ber_pkg::*;

   logic             enable;
   logic [SEL_W-1:0] select_chk;
   logic             prbs_in;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [TEB_W-1:0] teb_out;
   logic [TTB_W-1:0] ttb_out;
   logic             sat;

   modport master (
      output enable, select_chk, prbs_in, clear,
      input  locked, err_pulse, teb_out, ttb_out, sat
   );

   modport slave (
      input  enable, select_chk, prbs_in, clear,
      output locked, err_pulse, teb_out, ttb_out, sat
   );

endinterface

// File: rtl/ber_lfsr_predict.sv
// -----------------------------------------------------------------------------
// ber_lfsr_predict
// Local LFSR of the PRBS checker. In load mode the received bit is shifted in
// (self-synchronising); in free-run mode the predicted bit is fed back so the
// register tracks the ideal sequence regardless of channel errors.
//   clock, reset  clock / async active-low reset
//   enable        shift strobe
//   load          1 = shift in prbs_in, 0 = shift in the prediction
//   prbs_in       received bit
//   select_chk    polynomial select
//   pred          predicted next bit s[t1-1] ^ s[t2-1]
//   zero_state    low `order` bits of the register are all zero
//   order         polynomial order for the current select
// -----------------------------------------------------------------------------
module ber_lfsr_predict
   import ber_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic             prbs_in,
   input  logic [SEL_W-1:0] select_chk,
   output logic             pred,
   output logic             zero_state,
   output logic [4:0]       order
);

   poly_cfg_t         cfg;
   logic [LFSR_W-1:0] s;
   logic [LFSR_W-1:0] mask;

   assign cfg        = poly_cfg(poly_sel_e'(select_chk));
   assign order      = cfg.order;
   assign pred       = s[cfg.t1 - 5'd1] ^ s[cfg.t2 - 5'd1];
   // Only the low `order` bits belong to the active polynomial.
   assign mask       = (LFSR_W'(1) << cfg.order) - LFSR_W'(1);
   assign zero_state = ((s & mask) == '0);

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values of its neighbours, whatever the statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s <= '0;
      end else if (enable) begin
         s <= {s[LFSR_W-2:0], load ? prbs_in : pred};
      end
   end

endmodule

// File: rtl/ber_prbs_sync_checker.sv
// -----------------------------------------------------------------------------
// ber_prbs_sync_checker
// Receive-side PRBS checker: seeds a local LFSR from the incoming stream,
// verifies LOCK_CNT consecutive predictions, then free-runs and counts total
// and errored bits. Too many errors in one WINDOW, or a polynomial change,
// sends it back to re-acquisition.
//   clock, reset  clock / async active-low reset
//   bus           ber_prbs_sync_checker_if.slave (stream in, results out)
// -----------------------------------------------------------------------------
module ber_prbs_sync_checker
   import ber_pkg::*;
#(
   parameter int TEB_W       = 10,
   parameter int TTB_W       = 32,
   parameter int LOCK_CNT    = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8
) (
   input logic                    clock,
   input logic                    reset,
   ber_prbs_sync_checker_if.slave bus
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int WERR_W  = $clog2(WINDOW + 1);

   chk_state_e         state_q, state_d;
   logic [4:0]         seed_q, seed_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [WERR_W-1:0]  werr_q, werr_d, werr_inc;
   logic [SEL_W-1:0]   sel_q;
   logic [TTB_W-1:0]   ttb_q, ttb_inc;
   logic [TEB_W-1:0]   teb_q, teb_nxt;
   logic               sat_q, locked_q, err_pulse_q;
   logic               pred, zero_state, sel_change, bit_err, lock_bit;
   logic [4:0]         order;

   assign sel_change = (bus.select_chk != sel_q);
   assign bit_err    = pred ^ bus.prbs_in;
   // A bit is checked only while locked and while the polynomial is stable.
   assign lock_bit   = bus.enable & (state_q == LOCKED) & ~sel_change;
   assign werr_inc   = werr_q + WERR_W'(bit_err);

   ber_lfsr_predict u_lfsr (
      .clock      (clock),
      .reset      (reset),
      .enable     (bus.enable),
      .load       (state_q != LOCKED),
      .prbs_in    (bus.prbs_in),
      .select_chk (bus.select_chk),
      .pred       (pred),
      .zero_state (zero_state),
      .order      (order)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      match_d = match_q;
      win_d   = win_q;
      werr_d  = werr_q;
      if (sel_change) begin
         state_d = SEED;
         seed_d  = '0;
      end else if (bus.enable) begin
         case (state_q)
            SEED: begin
               if (seed_q == order - 5'd1) begin
                  state_d = TRACK;
                  seed_d  = '0;
                  match_d = '0;
               end else begin
                  seed_d = seed_q + 5'd1;
               end
            end
            TRACK: begin
               // An all-zero register predicts zeros forever: stuck-low input.
               if (zero_state || bit_err) begin
                  state_d = SEED;
                  seed_d  = '0;
               end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
                  win_d   = '0;
                  werr_d  = '0;
               end else begin
                  match_d = match_q + MATCH_W'(1);
               end
            end
            LOCKED: begin
               if (win_q == WIN_W'(WINDOW - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
                  if (werr_inc >= WERR_W'(LOSS_THRESH)) begin
                     state_d = SEED;
                     seed_d  = '0;
                  end
               end else begin
                  win_d  = win_q + WIN_W'(1);
                  werr_d = werr_inc;
               end
            end
            default: begin
               state_d = SEED;
               seed_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= SEED;
         seed_q  <= '0;
         match_q <= '0;
         win_q   <= '0;
         werr_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         match_q <= match_d;
         win_q   <= win_d;
         werr_q  <= werr_d;
         sel_q   <= bus.select_chk;
      end
   end

   assign ttb_inc = ttb_q + TTB_W'(1);
   assign teb_nxt = teb_q + TEB_W'(bit_err);

   // Counters freeze together once either hits all-ones (sat set); clear
   // has priority over any increment in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ttb_q       <= '0;
         teb_q       <= '0;
         sat_q       <= 1'b0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         locked_q    <= (state_d == LOCKED);
         err_pulse_q <= lock_bit & bit_err;
         if (bus.clear) begin
            ttb_q <= '0;
            teb_q <= '0;
            sat_q <= 1'b0;
         end else if (lock_bit && !sat_q) begin
            ttb_q <= ttb_inc;
            teb_q <= teb_nxt;
            sat_q <= (&ttb_inc) | (&teb_nxt);
         end
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.teb_out   = teb_q;
   assign bus.ttb_out   = ttb_q;
   assign bus.sat       = sat_q;

endmodule

// File: tb/tb_ber_prbs_sync_checker.sv
// -----------------------------------------------------------------------------
// tb_ber_prbs_sync_checker
// Two checkers share one stimulus stream: dut_a with default widths and dut_b
// with an 8-bit total-bit counter to reach saturation quickly. A behavioural
// model (bit history + mode/count variables) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_ber_prbs_sync_checker;

   localparam int     LOCK_CNT    = 32;
   localparam int     WINDOW      = 64;
   localparam int     LOSS_THRESH = 8;
   localparam longint TTB_MAX_A   = 64'hFFFF_FFFF;
   localparam longint TTB_MAX_B   = 255;
   localparam longint TEB_MAX     = 1023;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       prbs_in;
   logic       clear;
   logic [1:0] select_chk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_on = 0;

   ber_prbs_sync_checker_if #(.TEB_W(10), .TTB_W(32)) bus_a ();
   ber_prbs_sync_checker_if #(.TEB_W(10), .TTB_W(8))  bus_b ();

   assign bus_a.enable     = enable;
   assign bus_a.select_chk = select_chk;
   assign bus_a.prbs_in    = prbs_in;
   assign bus_a.clear      = clear;
   assign bus_b.enable     = enable;
   assign bus_b.select_chk = select_chk;
   assign bus_b.prbs_in    = prbs_in;
   assign bus_b.clear      = clear;

   ber_prbs_sync_checker #(.TEB_W(10), .TTB_W(32), .LOCK_CNT(LOCK_CNT),
      .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)) dut_a (
      .clock (clock), .reset (reset), .bus (bus_a.slave));

   ber_prbs_sync_checker #(.TEB_W(10), .TTB_W(8), .LOCK_CNT(LOCK_CNT),
      .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)) dut_b (
      .clock (clock), .reset (reset), .bus (bus_b.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ord_of(input logic [1:0] sel);
      case (sel)
         2'd0:    return 7;
         2'd1:    return 15;
         2'd2:    return 20;
         default: return 23;
      endcase
   endfunction

   function automatic int tap2_of(input logic [1:0] sel);
      case (sel)
         2'd0:    return 6;
         2'd1:    return 14;
         2'd2:    return 3;
         default: return 18;
      endcase
   endfunction

   // ---------------- transmitter-side PRBS source ----------------
   bit gh[23];
   int g_ord, g_t2;

   task automatic gen_init(input logic [1:0] sel);
      bit nz;
      g_ord = ord_of(sel);
      g_t2  = tap2_of(sel);
      nz    = 1'b0;
      while (!nz) begin
         for (int i = 0; i < 23; i++) gh[i] = 1'($urandom_range(1));
         for (int i = 0; i < g_ord; i++) if (gh[i]) nz = 1'b1;
      end
   endtask

   task automatic gen_next(output bit b);
      b = gh[g_ord-1] ^ gh[g_t2-1];
      for (int i = 22; i > 0; i--) gh[i] = gh[i-1];
      gh[0] = b;
   endtask

   // ---------------- behavioural reference model ----------------
   // mode: 0 = seeding, 1 = tracking, 2 = locked.
   // hist[k] is the (k+1)-th most recent bit fed into the local sequence.
   int         m_mode, m_seed, m_match, m_win, m_werr;
   logic [1:0] m_prev_sel;
   bit         hist[23];
   bit         m_locked, m_err, m_sat_a, m_sat_b;
   longint     m_ttb_a, m_teb_a, m_ttb_b, m_teb_b;

   task automatic model_reset();
      m_mode = 0; m_seed = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_prev_sel = 2'd0;
      for (int i = 0; i < 23; i++) hist[i] = 1'b0;
      m_locked = 0; m_err = 0; m_sat_a = 0; m_sat_b = 0;
      m_ttb_a = 0; m_teb_a = 0; m_ttb_b = 0; m_teb_b = 0;
   endtask

   task automatic model_step();
      int o, t2, nmode;
      bit p, e, zero, chg, lb, d;
      o  = ord_of(select_chk);
      t2 = tap2_of(select_chk);
      p  = hist[o-1] ^ hist[t2-1];
      zero = 1'b1;
      for (int i = 0; i < o; i++) if (hist[i]) zero = 1'b0;
      chg = (select_chk != m_prev_sel);
      lb  = enable && (m_mode == 2) && !chg;
      e   = (p != prbs_in);
      m_err = lb && e;

      if (clear) begin
         m_ttb_a = 0; m_teb_a = 0; m_sat_a = 0;
         m_ttb_b = 0; m_teb_b = 0; m_sat_b = 0;
      end else if (lb) begin
         if (!m_sat_a) begin
            m_ttb_a++; if (e) m_teb_a++;
            if (m_ttb_a == TTB_MAX_A || m_teb_a == TEB_MAX) m_sat_a = 1;
         end
         if (!m_sat_b) begin
            m_ttb_b++; if (e) m_teb_b++;
            if (m_ttb_b == TTB_MAX_B || m_teb_b == TEB_MAX) m_sat_b = 1;
         end
      end

      nmode = m_mode;
      if (chg) begin
         nmode = 0; m_seed = 0;
      end else if (enable) begin
         if (m_mode == 0) begin
            m_seed++;
            if (m_seed == o) begin nmode = 1; m_seed = 0; m_match = 0; end
         end else if (m_mode == 1) begin
            if (zero || e) begin
               nmode = 0; m_seed = 0;
            end else begin
               m_match++;
               if (m_match == LOCK_CNT) begin nmode = 2; m_win = 0; m_werr = 0; end
            end
         end else begin
            m_win++;
            if (e) m_werr++;
            if (m_win == WINDOW) begin
               if (m_werr >= LOSS_THRESH) begin nmode = 0; m_seed = 0; end
               m_win = 0; m_werr = 0;
            end
         end
      end

      if (enable) begin
         d = (m_mode == 2) ? p : prbs_in;
         for (int i = 22; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = d;
      end
      m_mode     = nmode;
      m_prev_sel = select_chk;
      m_locked   = (m_mode == 2);
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   // ---------------- per-cycle compare and event monitor ----------------
   int pulse_cnt = 0;
   int rise_cnt  = 0;
   bit prev_pulse = 0;
   bit ever_locked = 0;

   always @(negedge clock) begin
      if (reset && check_on) begin
         check("locked_a",    bus_a.locked,    64'(m_locked));
         check("err_pulse_a", bus_a.err_pulse, 64'(m_err));
         check("teb_a",       bus_a.teb_out,   64'(m_teb_a));
         check("ttb_a",       bus_a.ttb_out,   64'(m_ttb_a));
         check("sat_a",       bus_a.sat,       64'(m_sat_a));
         check("locked_b",    bus_b.locked,    64'(m_locked));
         check("err_pulse_b", bus_b.err_pulse, 64'(m_err));
         check("teb_b",       bus_b.teb_out,   64'(m_teb_b));
         check("ttb_b",       bus_b.ttb_out,   64'(m_ttb_b));
         check("sat_b",       bus_b.sat,       64'(m_sat_b));
         if (bus_a.err_pulse) pulse_cnt++;
         if (bus_a.err_pulse && !prev_pulse) rise_cnt++;
         prev_pulse = bus_a.err_pulse;
         if (bus_a.locked) ever_locked = 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input logic en_v, input logic din_v);
      enable  = en_v;
      prbs_in = din_v;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input bit flip);
      bit b;
      gen_next(b);
      cycle(1'b1, b ^ flip);
   endtask

   task automatic idle();
      cycle(1'b0, 1'($urandom_range(1)));
   endtask

   // Feed clean PRBS until dut_a locks or the cycle budget expires.
   task automatic acquire(input int budget, input bit gaps, output int nbits);
      nbits = 0;
      for (int i = 0; i < budget && !bus_a.locked; i++) begin
         if (gaps && $urandom_range(3) == 0) idle();
         else begin send(1'b0); nbits++; end
      end
      check("acquire_lock", bus_a.locked, 1);
   endtask

   logic [63:0] teb0, ttb0;
   int          nb;

   initial begin
      reset = 1'b0; enable = 1'b0; prbs_in = 1'b0; clear = 1'b0; select_chk = 2'b00;
      #12;
      check("rst_locked",    bus_a.locked,    0);
      check("rst_err_pulse", bus_a.err_pulse, 0);
      check("rst_teb",       bus_a.teb_out,   0);
      check("rst_ttb",       bus_a.ttb_out,   0);
      check("rst_sat",       bus_a.sat,       0);
      @(negedge clock);
      reset    = 1'b1;
      check_on = 1'b1;

      // Error-free PRBS7, continuous enable: lock after 7 + 32 bits.
      gen_init(2'b00);
      for (int i = 0; i < 38; i++) send(1'b0);
      check("prbs7_not_locked_38", bus_a.locked, 0);
      send(1'b0);
      check("prbs7_locked_39", bus_a.locked, 1);
      for (int i = 0; i < 1000; i++) send(1'b0);
      check("prbs7_ttb_1000",   bus_a.ttb_out, 1000);
      check("prbs7_teb_0",      bus_a.teb_out, 0);
      check("prbs7_sat_a_0",    bus_a.sat,     0);
      check("model_ttb_1000",   m_ttb_a,       1000);
      // 8-bit total counter saturates, error counter frozen with it.
      check("sat8_ttb_255",     bus_b.ttb_out, 255);
      check("sat8_flag",        bus_b.sat,     1);
      check("sat8_teb_frozen",  bus_b.teb_out, 0);
      clear = 1'b1; idle(); clear = 1'b0;
      check("clear_ttb_b",      bus_b.ttb_out, 0);
      check("clear_sat_b",      bus_b.sat,     0);
      check("clear_ttb_a",      bus_a.ttb_out, 0);

      // PRBS15 with gaps, then three isolated bit errors.
      select_chk = 2'b01; idle();
      check("sel_change_unlock", bus_a.locked, 0);
      gen_init(2'b01);
      acquire(600, 1'b1, nb);
      pulse_cnt = 0; rise_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) idle();
         send(i == 50 || i == 150 || i == 250);
      end
      idle();
      check("prbs15_teb_3",       bus_a.teb_out, 3);
      check("prbs15_pulse_cycles", 64'(pulse_cnt), 3);
      check("prbs15_pulse_edges",  64'(rise_cnt),  3);
      check("prbs15_still_locked", bus_a.locked,  1);

      // PRBS23: 8 errors at the start of the first window force re-acquisition.
      select_chk = 2'b11; idle();
      gen_init(2'b11);
      acquire(200, 1'b0, nb);
      check("prbs23_acq_bits", 64'(nb), 55);
      teb0 = 64'(bus_a.teb_out);
      ttb0 = 64'(bus_a.ttb_out);
      for (int i = 0; i < 63; i++) send(i < 8);
      check("prbs23_locked_before_boundary", bus_a.locked, 1);
      send(1'b0);
      check("prbs23_unlocked_after_boundary", bus_a.locked, 0);
      check("prbs23_teb_plus8",  bus_a.teb_out, teb0 + 8);
      check("prbs23_ttb_plus64", bus_a.ttb_out, ttb0 + 64);
      for (int i = 0; i < 54; i++) send(1'b0);
      check("prbs23_relock_not_yet", bus_a.locked, 0);
      check("prbs23_teb_hold",       bus_a.teb_out, teb0 + 8);
      check("prbs23_ttb_hold",       bus_a.ttb_out, ttb0 + 64);
      send(1'b0);
      check("prbs23_relocked", bus_a.locked, 1);

      // Stuck-low input never locks.
      select_chk = 2'b00; clear = 1'b1; cycle(1'b0, 1'b0); clear = 1'b0;
      ever_locked = 1'b0;
      for (int i = 0; i < 10000; i++) cycle(1'($urandom_range(3) != 0), 1'b0);
      check("stuck_never_locked", 64'(ever_locked), 0);
      check("stuck_teb_0", bus_a.teb_out, 0);
      check("stuck_ttb_0", bus_a.ttb_out, 0);

      // Lock on PRBS7, then switch to PRBS15 mid-stream.
      gen_init(2'b00);
      acquire(300, 1'b0, nb);
      for (int i = 0; i < 100; i++) send(1'b0);
      select_chk = 2'b01; idle();
      check("switch_unlock_next_cycle", bus_a.locked, 0);
      gen_init(2'b01);
      for (int i = 0; i < 46; i++) send(1'b0);
      check("switch_relock_not_yet", bus_a.locked, 0);
      send(1'b0);
      check("switch_relock_47", bus_a.locked, 1);

      // Randomised soak with varying error rates and sporadic clears.
      for (int seg = 0; seg < 4; seg++) begin
         logic [1:0] sel;
         int         rate;
         sel  = 2'($urandom_range(3));
         rate = (seg == 0) ? 60 : (seg == 1) ? 12 : (seg == 2) ? 0 : 30;
         select_chk = sel; idle();
         gen_init(sel);
         for (int i = 0; i < 2500; i++) begin
            clear = ($urandom_range(499) == 0);
            if ($urandom_range(99) < 20) idle();
            else send(rate != 0 && $urandom_range(rate - 1) == 0);
         end
         clear = 1'b0;
      end

      // Asynchronous reset in the middle of locked operation.
      select_chk = 2'b10; idle();
      gen_init(2'b10);
      acquire(300, 1'b0, nb);
      for (int i = 0; i < 20; i++) send(1'b0);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst_locked", bus_a.locked,    0);
      check("async_rst_err",    bus_a.err_pulse, 0);
      check("async_rst_teb",    bus_a.teb_out,   0);
      check("async_rst_ttb",    bus_a.ttb_out,   0);
      check("async_rst_sat_b",  bus_b.sat,       0);
      @(negedge clock);
      reset = 1'b1;
      acquire(400, 1'b1, nb);
      for (int i = 0; i < 200; i++) send(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
